// File: rtl/master_pkg.sv
// Shared definitions for the Wishbone-style bus master: bus width defaults,
// operation codes and FSM state encodings.
package master_pkg;

  localparam int unsigned ADR_MSB_DEF  = 31;
  localparam int unsigned DATA_MSB_DEF = 31;
  localparam int unsigned SEL_MSB_DEF  = 3;
  localparam int unsigned TAG_MSB_DEF  = 3;

  typedef enum logic [1:0] {
    FUNC_READ  = 2'b00,
    FUNC_WRITE = 2'b01,
    FUNC_RMW   = 2'b10,
    FUNC_IDLE  = 2'b11
  } func_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } state_e;

endpackage

// File: rtl/master_if.sv
// Bus bundle between the master and its slave. Signal names carry the
// master's point of view (_i driven by the slave, _o driven by the master).
interface master_if
  import master_pkg::*;
#(
  parameter int unsigned ADR_MSB  = ADR_MSB_DEF,
  parameter int unsigned DATA_MSB = DATA_MSB_DEF,
  parameter int unsigned SEL_MSB  = SEL_MSB_DEF,
  parameter int unsigned TAG_MSB  = TAG_MSB_DEF
);

  logic [1:0]        func_i;
  logic [DATA_MSB:0] dat_i;
  logic [TAG_MSB:0]  tgd_i;
  logic              ack_i;

  logic [ADR_MSB:0]  adr_o;
  logic [DATA_MSB:0] dat_o;
  logic [SEL_MSB:0]  sel_o;
  logic              we_o;
  logic              stb_o;
  logic              cyc_o;
  logic [TAG_MSB:0]  tga_o;
  logic [TAG_MSB:0]  tgd_o;
  logic [TAG_MSB:0]  tgc_o;

  modport master (
    input  func_i, dat_i, tgd_i, ack_i,
    output adr_o, dat_o, sel_o, we_o, stb_o, cyc_o, tga_o, tgd_o, tgc_o
  );

  modport slave (
    output func_i, dat_i, tgd_i, ack_i,
    input  adr_o, dat_o, sel_o, we_o, stb_o, cyc_o, tga_o, tgd_o, tgc_o
  );

endinterface

// File: rtl/master.sv
// Wishbone bus master issuing read, write and read-modify-write cycles over an
// auto-incrementing address; every output is driven straight from a register.
module master
  import master_pkg::*;
#(
  parameter int unsigned ADR_MSB  = ADR_MSB_DEF,
  parameter int unsigned DATA_MSB = DATA_MSB_DEF,
  parameter int unsigned SEL_MSB  = SEL_MSB_DEF,
  parameter int unsigned TAG_MSB  = TAG_MSB_DEF
) (
  input  logic     clk_i,
  input  logic     rst_i,
  master_if.master bus
);

  localparam int unsigned AdrW    = ADR_MSB + 1;
  localparam int unsigned DatW    = DATA_MSB + 1;
  localparam int unsigned TagW    = TAG_MSB + 1;
  localparam int unsigned AdrStep = DatW / 8;

  state_e            state_q;
  func_e             func_q;
  logic [ADR_MSB:0]  adr_q;
  logic [DATA_MSB:0] wd_q;
  logic [SEL_MSB:0]  sel_q;
  logic              we_q;
  logic              stb_q;
  logic              cyc_q;
  logic [TAG_MSB:0]  tga_q;
  logic [TAG_MSB:0]  tgd_q;
  logic [TAG_MSB:0]  tgc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      func_q  <= FUNC_READ;
      adr_q   <= '0;
      wd_q    <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      cyc_q   <= 1'b0;
      tga_q   <= '0;
      tgd_q   <= '0;
      tgc_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (func_e'(bus.func_i) != FUNC_IDLE) begin
            func_q <= func_e'(bus.func_i);
            tgc_q  <= TagW'(bus.func_i);
            cyc_q  <= 1'b1;
            stb_q  <= 1'b1;
            sel_q  <= '1;
            if (func_e'(bus.func_i) == FUNC_WRITE) begin
              state_q <= StWrite;
              we_q    <= 1'b1;
            end else begin
              state_q <= StRead;
            end
          end
        end

        StRead: begin
          if (bus.ack_i) begin
            tgd_q <= bus.tgd_i;
            if (func_q == FUNC_RMW) begin
              // Fold the RMW increment into the latch so dat_o stays a bare register.
              wd_q    <= bus.dat_i + DatW'(1);
              we_q    <= 1'b1;
              state_q <= StWrite;
            end else begin
              wd_q    <= bus.dat_i;
              cyc_q   <= 1'b0;
              stb_q   <= 1'b0;
              sel_q   <= '0;
              adr_q   <= adr_q + AdrW'(AdrStep);
              tga_q   <= tga_q + TagW'(1);
              state_q <= StIdle;
            end
          end
        end

        StWrite: begin
          if (bus.ack_i) begin
            if (func_q == FUNC_WRITE) begin
              wd_q <= wd_q + DatW'(1);
            end
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= adr_q + AdrW'(AdrStep);
            tga_q   <= tga_q + TagW'(1);
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.adr_o = adr_q;
  assign bus.dat_o = wd_q;
  assign bus.sel_o = sel_q;
  assign bus.we_o  = we_q;
  assign bus.stb_o = stb_q;
  assign bus.cyc_o = cyc_q;
  assign bus.tga_o = tga_q;
  assign bus.tgd_o = tgd_q;
  assign bus.tgc_o = tgc_q;

endmodule

// File: tb/tb_master.sv
// Scoreboard bench for master: expected bus beats are queued as stimulus is
// issued and a forked monitor compares every acknowledged beat.
module tb_master;
  import master_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  master_if bus ();
  master_if #(.ADR_MSB(3)) bus2 ();

  master dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.master)
  );

  master #(.ADR_MSB(3)) dut2 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus2.master)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  tga;
    logic [3:0]  tgc;
    logic [3:0]  tgd;
    int          gap;
  } beat_t;

  beat_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] tga, input logic [3:0] tgc, input logic [3:0] tgd,
                      input int gap);
    beat_t b;
    b.adr = adr; b.we = we; b.dat = dat; b.tga = tga; b.tgc = tgc; b.tgd = tgd; b.gap = gap;
    exp_q.push_back(b);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, 64'({bus.cyc_o, bus.stb_o, bus.we_o, bus.sel_o,
                                bus.tga_o, bus.tgd_o, bus.tgc_o}), 64'(0));
    check({name, "_adr_dat"}, {bus.adr_o, bus.dat_o}, 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #13;
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("no_early_start", 64'(bus.cyc_o), 64'(0));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    check({"drain_", name}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic set_in(input logic [1:0] f, input logic a, input logic [31:0] d,
                        input logic [3:0] t);
    bus.func_i = f; bus.ack_i = a; bus.dat_i = d; bus.tgd_i = t;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc_cnt;
    int last_beat;
    beat_t e;
    int beats;

    cyc_cnt = 0;
    last_beat = 0;
    set_in(FUNC_READ, 1'b0, 32'h1234_5678, 4'h0);
    bus2.func_i = FUNC_IDLE; bus2.ack_i = 1'b0; bus2.dat_i = '0; bus2.tgd_i = '0;

    fork
      forever begin
        @(negedge clk);
        cyc_cnt++;
        if (bus.cyc_o && bus.stb_o && bus.ack_i) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_beat: adr 0x%0h we %0b, none queued", bus.adr_o, bus.we_o);
          end else begin
            e = exp_q.pop_front();
            check("beat_adr", 64'(bus.adr_o), 64'(e.adr));
            check("beat_we",  64'(bus.we_o),  64'(e.we));
            check("beat_dat", 64'(bus.dat_o), 64'(e.dat));
            check("beat_sel", 64'(bus.sel_o), 64'(4'hF));
            check("beat_tga", 64'(bus.tga_o), 64'(e.tga));
            check("beat_tgc", 64'(bus.tgc_o), 64'(e.tgc));
            check("beat_tgd", 64'(bus.tgd_o), 64'(e.tgd));
            if (e.gap != 0) check("beat_gap", 64'(cyc_cnt - last_beat), 64'(e.gap));
          end
          last_beat = cyc_cnt;
        end
      end
    join_none

    // Reads stalled without ack, then streamed with ack held high.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("hold_read", 64'({bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o}),
            64'({1'b1, 1'b1, 1'b0, 32'h0}));
      if (i == 10) bus.func_i = FUNC_WRITE;
      if (i == 20) bus.func_i = FUNC_READ;
    end
    push(32'h0, 1'b0, 32'h0,         4'd0, 4'd0, 4'd0, 0);
    push(32'h4, 1'b0, 32'h1234_5678, 4'd1, 4'd0, 4'd0, 2);
    push(32'h8, 1'b0, 32'h1234_5678, 4'd2, 4'd0, 4'd0, 2);
    push(32'hC, 1'b0, 32'h1234_5678, 4'd3, 4'd0, 4'd0, 2);
    @(posedge clk);
    #1 bus.ack_i = 1'b1;
    wait_drain("read");
    bus.func_i = FUNC_IDLE;
    repeat (4) @(negedge clk);
    check("idle_after_read", 64'(bus.cyc_o), 64'(0));
    check("adr_after_read", 64'(bus.adr_o), 64'(32'h10));

    // Plain writes with ack held from reset.
    set_in(FUNC_WRITE, 1'b1, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) push(32'(4 * i), 1'b1, 32'(i), 4'(i), 4'd1, 4'd0, (i == 0) ? 0 : 2);
    do_reset();
    wait_drain("write");
    bus.func_i = FUNC_IDLE;
    repeat (3) @(negedge clk);

    // Read-modify-write pairs.
    set_in(FUNC_RMW, 1'b1, 32'h0000_00FF, 4'h5);
    push(32'h0, 1'b0, 32'h0,   4'd0, 4'd2, 4'd0, 0);
    push(32'h0, 1'b1, 32'h100, 4'd0, 4'd2, 4'd5, 1);
    push(32'h4, 1'b0, 32'h100, 4'd1, 4'd2, 4'd5, 2);
    push(32'h4, 1'b1, 32'h100, 4'd1, 4'd2, 4'd5, 1);
    do_reset();
    wait_drain("rmw");
    bus.func_i = FUNC_IDLE;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a read.
    set_in(FUNC_READ, 1'b0, 32'h0, 4'h0);
    do_reset();
    repeat (3) @(negedge clk);
    check("in_read_before_rst", 64'(bus.cyc_o), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    bus.func_i = FUNC_IDLE;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_rst", 64'({bus.cyc_o, bus.stb_o}), 64'(0));
    end

    // 4-bit address wraps after the read at address 12.
    beats = 0;
    @(negedge clk);
    bus2.func_i = FUNC_READ;
    bus2.ack_i  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus2.cyc_o && bus2.stb_o && bus2.ack_i) begin
        beats++;
        if (beats == 4) begin
          check("wrap_pre_adr", 64'(bus2.adr_o), 64'(12));
          bus2.func_i = FUNC_IDLE;
          break;
        end
      end
    end
    check("wrap_beats", 64'(beats), 64'(4));
    repeat (3) @(negedge clk);
    check("wrap_adr", 64'(bus2.adr_o), 64'(0));
    check("wrap_tga", 64'(bus2.tga_o), 64'(4));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/master.md
MASTER -- requirements
Module: master

Interface
REQ-001 Parameter ADR_MSB, default 31, address bus MSB.
REQ-002 Parameter DATA_MSB, default 31, data bus MSB; (DATA_MSB+1) SHALL be a multiple of 8.
REQ-003 Parameter SEL_MSB, default 3, byte-select MSB; SHALL equal (DATA_MSB+1)/8-1.
REQ-004 Parameter TAG_MSB, default 3, tag bus MSB.
REQ-005 clk_i  in  1  single clock; all state SHALL change on its rising edge.
REQ-006 rst_i  in  1  asynchronous, active-low reset.
REQ-007 func_i  in  2  operation: 00 read, 01 write, 10 read-modify-write (RMW), 11 idle.
REQ-008 dat_i  in  DATA_MSB+1  read data from slave.
REQ-009 tgd_i  in  TAG_MSB+1  read-data tag from slave.
REQ-010 ack_i  in  1  slave acknowledge.
REQ-011 adr_o  out  ADR_MSB+1  byte address.
REQ-012 dat_o  out  DATA_MSB+1  write data.
REQ-013 sel_o  out  SEL_MSB+1  byte selects.
REQ-014 we_o, stb_o, cyc_o  out  1 each  Wishbone write enable, strobe, cycle.
REQ-015 tga_o, tgd_o, tgc_o  out  TAG_MSB+1 each  address, data and cycle tags.

Function
REQ-016 FSM states: IDLE, READ, WRITE. All outputs SHALL be registered.
REQ-017 IDLE: cyc_o=stb_o=we_o=0. func_i is sampled here only. 00 or 10 -> READ. 01 -> WRITE. 11 -> stay in IDLE.
REQ-018 READ: cyc_o=stb_o=1, we_o=0. The state SHALL hold until ack_i=1 is sampled.
REQ-019 On the READ ack edge: dat_i is latched into the data register wd_q and tgd_i into the tag register.
REQ-020 After a READ ack: for a plain read, go to IDLE. For RMW, go directly to WRITE with cyc_o held at 1 (stb_o stays 1) and the address unchanged.
REQ-021 WRITE: cyc_o=stb_o=we_o=1 and dat_o=wd_q. The state SHALL hold until ack_i=1, then go to IDLE.
REQ-022 Write data: a plain write drives wd_q and then wd_q increments by 1 on ack. An RMW write drives the latched read data plus 1.
REQ-023 Address counter: adr_o SHALL increment by (DATA_MSB+1)/8 when a transaction completes (plain read ack, plain write ack, or RMW write ack), wrapping modulo 2^(ADR_MSB+1).
REQ-024 sel_o SHALL be all ones whenever stb_o=1, and 0 otherwise.
REQ-025 Tag outputs:
- tgc_o = func latched at the start of the cycle, zero-extended.
- tga_o = count of completed transactions modulo 2^(TAG_MSB+1).
- tgd_o = last latched tgd_i.
REQ-026 Timing: one cycle of cyc_o=0 (IDLE) SHALL separate consecutive transactions. With ack_i held high, each read or write occupies 1 bus cycle plus 1 IDLE cycle, and each RMW occupies 2 bus cycles plus 1 IDLE cycle.
REQ-027 ack_i is ignored while stb_o=0.
REQ-028 Changes on func_i during READ or WRITE SHALL have no effect until the next IDLE.
REQ-029 There is no timeout: a missing ack SHALL hold the bus indefinitely.

Reset
REQ-030 rst_i=0 SHALL immediately force state IDLE and all outputs, the address counter, wd_q, the tag registers and the transaction count to 0, including in the middle of a bus cycle.
REQ-031 The first transaction SHALL start no earlier than the second rising edge after rst_i deasserts (one IDLE sample edge, then the bus cycle).

Structure
REQ-032 The shared package SHALL hold the ADR/DATA/SEL/TAG MSB defaults, the func encodings (FUNC_READ, FUNC_WRITE, FUNC_RMW, FUNC_IDLE) and the state encodings.
REQ-033 A single module SHALL be used. The FSM, counters and data path SHALL be inline, with no sub-module.

Verification
REQ-034 Reset, then func_i=00 with ack_i=0 for 25 cycles -> cyc_o=stb_o=1, we_o=0, adr_o=0 held throughout; no increment.
REQ-035 Then ack_i=1 held with dat_i=0x12345678 -> adr_o steps 0,4,8,... every 2 cycles, and tga_o increments per transaction.
REQ-036 func_i=01 from reset, ack_i=1 held -> successive writes with dat_o=0,1,2,..., we_o=1, sel_o=0xF.
REQ-037 func_i=10, dat_i=0x000000FF, tgd_i=0x5 -> read at adr 0, then write at adr 0 with dat_o=0x100 and tgd_o=5; the next RMW is at adr 4.
REQ-038 rst_i pulsed low during READ -> all outputs 0 asynchronously. After release with func_i=11 -> cyc_o stays 0.
REQ-039 ADR_MSB=3, address 12, one completed read -> adr_o wraps to 0.
